// File: rtl/gauss_frame_sequencer.sv
// Frame controller for one Gaussian blur stage: feeds line pixels, per-line zero pads and a
// zero flush into the filter, and gates downstream writes until the filter pipeline is primed.
module gauss_frame_sequencer #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 800,
  parameter int unsigned IMG_H = 600,
  parameter int unsigned PAD   = 2,
  parameter int unsigned PRIME = 799,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          g_en,
  output logic [DW-1:0] g_din,
  input  logic          out_full,
  output logic          out_wr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINE,
    S_PAD,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(IMG_H - 1);
  localparam logic [CW-1:0] PAD_LAST   = CW'((PAD > 0) ? PAD - 1 : 0);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((PRIME > 0) ? PRIME - 1 : 0);
  localparam logic [CW-1:0] PRIME_MAX  = CW'(PRIME);
  localparam state_t        AFTER_LAST = (PRIME > 0) ? S_FLUSH : S_DONE;

  state_t        state;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;
  logic [CW-1:0] pad_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] prime_cnt;

  // Filter feed: pixels pass through only in LINE; pad and flush shift in zeros.
  always_comb begin
    in_ready = 1'b0;
    g_en     = 1'b0;
    g_din    = '0;
    case (state)
      S_LINE: begin
        in_ready = in_valid & ~out_full;
        g_en     = in_valid & ~out_full;
        g_din    = (in_valid & ~out_full) ? in_data : '0;
      end
      S_PAD, S_FLUSH: g_en = ~out_full;
      default: ;
    endcase
  end

  assign out_wr = g_en & (prime_cnt == PRIME_MAX);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      pad_cnt   <= '0;
      flush_cnt <= '0;
      prime_cnt <= '0;
    end else begin
      // Prime counter survives across lines; only start or reset clears it.
      if (g_en && (prime_cnt != PRIME_MAX)) prime_cnt <= prime_cnt + CW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LINE;
            col_cnt   <= '0;
            row_cnt   <= '0;
            pad_cnt   <= '0;
            flush_cnt <= '0;
            prime_cnt <= '0;
          end
        end
        S_LINE: begin
          if (g_en) begin
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              if (PAD > 0) begin
                state <= S_PAD;
              end else if (row_cnt != ROW_LAST) begin
                row_cnt <= row_cnt + CW'(1);
              end else begin
                state <= AFTER_LAST;
              end
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
        end
        S_PAD: begin
          if (g_en) begin
            if (pad_cnt == PAD_LAST) begin
              pad_cnt <= '0;
              if (row_cnt != ROW_LAST) begin
                row_cnt <= row_cnt + CW'(1);
                state   <= S_LINE;
              end else begin
                state <= AFTER_LAST;
              end
            end else begin
              pad_cnt <= pad_cnt + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (g_en) begin
            if (flush_cnt == FLUSH_LAST) begin
              flush_cnt <= '0;
              state     <= S_DONE;
            end else begin
              flush_cnt <= flush_cnt + CW'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
